// File: rtl/intr_seq_ctrl.sv
// intr_seq_ctrl: hard/soft interrupt sequencer.
// Latches requests, drains the pipe, then redirects fetch into the shadow context.
module intr_seq_ctrl #(
  parameter int P_WORD_BITS   = 32,
  parameter int P_H_CODE_BITS = 4,
  parameter int P_S_CODE_BITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_h_intr,
  input  logic [P_H_CODE_BITS-1:0] i_h_intr_code,
  input  logic                     i_s_intr,
  input  logic [P_S_CODE_BITS-1:0] i_s_intr_code,
  input  logic                     i_inst_complete,
  input  logic                     i_fetch_idle,
  input  logic                     i_intr_finish,
  input  logic                     i_mask_write,
  input  logic [1:0]               i_mask_data,
  input  logic                     i_vec_base_write,
  input  logic [P_WORD_BITS-1:0]   i_vec_base_data,
  output logic                     o_intring,
  output logic                     o_intr_jump,
  output logic [P_WORD_BITS-1:0]   o_intr_addr,
  output logic [P_H_CODE_BITS-1:0] o_h_code,
  output logic [P_S_CODE_BITS-1:0] o_s_code,
  output logic [1:0]               o_pending
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_ENTER,
    S_SERVICE,
    S_EXIT
  } state_t;

  localparam logic [P_WORD_BITS-1:0] SoftOfs = P_WORD_BITS'(64);

  state_t                   state_q, state_d;
  logic [1:0]               pend_q, pend_d;
  logic [P_H_CODE_BITS-1:0] h_pcode_q, h_pcode_d;
  logic [P_S_CODE_BITS-1:0] s_pcode_q, s_pcode_d;
  logic [1:0]               mask_q, mask_d;
  logic [P_WORD_BITS-1:0]   vec_q, vec_d;
  logic                     sel_h_q, sel_h_d;
  logic [P_WORD_BITS-1:0]   addr_q, addr_d;
  logic [P_H_CODE_BITS-1:0] h_code_q, h_code_d;
  logic [P_S_CODE_BITS-1:0] s_code_q, s_code_d;

  logic                     enter_go;
  logic                     clr_h, clr_s;
  logic                     set_h, set_s;
  logic [P_WORD_BITS-1:0]   h_off, s_off;

  // Sequencer next-state
  always_comb begin
    state_d  = state_q;
    enter_go = 1'b0;
    case (state_q)
      S_IDLE:    if (|pend_q) state_d = S_DRAIN;
      S_DRAIN: begin
        if (i_inst_complete || i_fetch_idle) begin
          state_d  = S_ENTER;
          enter_go = 1'b1;
        end
      end
      S_ENTER:   state_d = S_SERVICE;
      S_SERVICE: if (i_intr_finish) state_d = S_EXIT;
      S_EXIT:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Pending flags: first code wins, a new request beats the ENTER clear
  always_comb begin
    clr_h     = (state_q == S_ENTER) && sel_h_q;
    clr_s     = (state_q == S_ENTER) && !sel_h_q;
    set_h     = i_h_intr && !mask_q[0] && (!pend_q[0] || clr_h);
    set_s     = i_s_intr && !mask_q[1] && (!pend_q[1] || clr_s);
    pend_d    = {set_s || (pend_q[1] && !clr_s),
                 set_h || (pend_q[0] && !clr_h)};
    h_pcode_d = set_h ? i_h_intr_code : h_pcode_q;
    s_pcode_d = set_s ? i_s_intr_code : s_pcode_q;
    mask_d    = i_mask_write ? i_mask_data : mask_q;
    vec_d     = i_vec_base_write ? i_vec_base_data : vec_q;
  end

  // Entry registers: class select, handler address and active codes
  always_comb begin
    sel_h_d  = sel_h_q;
    addr_d   = addr_q;
    h_code_d = h_code_q;
    s_code_d = s_code_q;
    h_off    = P_WORD_BITS'(h_pcode_q) << 2;
    s_off    = P_WORD_BITS'(s_pcode_q) << 2;
    if (enter_go) begin
      sel_h_d = pend_q[0];
      if (pend_q[0]) begin
        addr_d   = vec_q + h_off;
        h_code_d = h_pcode_q;
        s_code_d = '0;
      end else begin
        addr_d   = vec_q + SoftOfs + s_off;
        h_code_d = '0;
        s_code_d = s_pcode_q;
      end
    end
    if ((state_q == S_SERVICE) && i_intr_finish) begin
      h_code_d = '0;
      s_code_d = '0;
    end
  end

  // State and register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= '0;
      h_pcode_q <= '0;
      s_pcode_q <= '0;
      mask_q    <= '0;
      vec_q     <= '0;
      sel_h_q   <= 1'b0;
      addr_q    <= '0;
      h_code_q  <= '0;
      s_code_q  <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      h_pcode_q <= h_pcode_d;
      s_pcode_q <= s_pcode_d;
      mask_q    <= mask_d;
      vec_q     <= vec_d;
      sel_h_q   <= sel_h_d;
      addr_q    <= addr_d;
      h_code_q  <= h_code_d;
      s_code_q  <= s_code_d;
    end
  end

  assign o_intr_jump = (state_q == S_ENTER);
  assign o_intring   = (state_q == S_ENTER) || (state_q == S_SERVICE);
  assign o_intr_addr = addr_q;
  assign o_h_code    = h_code_q;
  assign o_s_code    = s_code_q;
  assign o_pending   = pend_q;

endmodule

// File: doc/intr_seq_ctrl.md
INTR_SEQ_CTRL -- requirements
Module: intr_seq_ctrl

Interface
REQ-001 SHALL have parameter P_WORD_BITS, default 32, address/data word width.
REQ-002 SHALL have parameter P_H_CODE_BITS, default 4, hard interrupt code width.
REQ-003 SHALL have parameter P_S_CODE_BITS, default 4, soft interrupt code width.
REQ-004 SHALL have port clk  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_h_intr  in  1  hard interrupt request, level sampled each cycle.
REQ-007 SHALL have port i_h_intr_code  in  P_H_CODE_BITS  hard code, valid with i_h_intr.
REQ-008 SHALL have port i_s_intr  in  1  soft interrupt request.
REQ-009 SHALL have port i_s_intr_code  in  P_S_CODE_BITS  soft code, valid with i_s_intr.
REQ-010 SHALL have port i_inst_complete  in  1  one-cycle pulse at instruction retirement.
REQ-011 SHALL have port i_fetch_idle  in  1  instruction FIFO empty and no fetch outstanding.
REQ-012 SHALL have port i_intr_finish  in  1  return-from-interrupt pulse from decode.
REQ-013 SHALL have port i_mask_write / i_mask_data  in  1 / 2  mask register write; bit0 masks hard, bit1 masks soft.
REQ-014 SHALL have port i_vec_base_write / i_vec_base_data  in  1 / P_WORD_BITS  vector base write.
REQ-015 SHALL have port o_intring  out  1  shadow context select (register file, FIFOs, fetch).
REQ-016 SHALL have port o_intr_jump  out  1  one-cycle redirect pulse to fetch control.
REQ-017 SHALL have port o_intr_addr  out  P_WORD_BITS  handler address, valid while o_intr_jump high and held through service.
REQ-018 SHALL have port o_h_code / o_s_code  out  P_H_CODE_BITS / P_S_CODE_BITS  active code, 0 = NONE.
REQ-019 SHALL have port o_pending  out  2  {soft, hard} pending flags.

Function
REQ-020 SHALL latch hard pending when i_h_intr=1, mask bit0=0 and hard not already pending; code captured at that edge; later requests while pending ignored (first code wins).
REQ-021 SHALL latch soft pending identically using i_s_intr, mask bit1, i_s_intr_code.
REQ-022 SHALL NOT clear an already-latched pending flag on mask write; mask affects only new requests.
REQ-023 SHALL implement FSM IDLE, DRAIN, ENTER, SERVICE, EXIT.
REQ-024 IDLE -> DRAIN on cycle after any pending flag is 1.
REQ-025 DRAIN -> ENTER on i_inst_complete=1 or i_fetch_idle=1; otherwise hold.
REQ-026 ENTER (exactly 1 cycle): select hard if hard pending else soft; clear selected pending; assert o_intr_jump; set o_intring=1; load selected code into its output, other code output = 0; -> SERVICE.
REQ-027 o_intr_addr SHALL be registered in ENTER: hard = vec_base + (code << 2); soft = vec_base + 0x40 + (code << 2); sums modulo 2^P_WORD_BITS.
REQ-028 SERVICE: hold o_intring=1; -> EXIT on i_intr_finish=1; requests arriving during SERVICE latch as pending (no nesting).
REQ-029 EXIT (exactly 1 cycle): o_intring=0, both code outputs=0, -> IDLE; a remaining pending flag is re-serviced via IDLE->DRAIN.
REQ-030 SHALL ignore i_intr_finish in any state other than SERVICE.
REQ-031 Request arriving in the same cycle as ENTER's pending clear of the same class SHALL be latched as new pending (set wins over clear for the next request).
REQ-032 vec_base write SHALL take effect the following cycle; an ENTER in the write cycle uses the old value.
REQ-033 Simultaneous hard and soft arrival SHALL latch both; hard serviced first, soft after EXIT.

Reset
REQ-034 On rst: state IDLE, pending=2'b00, mask=2'b00, vec_base=0, o_intring=0, o_intr_jump=0, o_intr_addr=0, o_h_code=0, o_s_code=0; rst mid-service aborts immediately with these values.

Verification
REQ-035 vec_base=0x1000, hard code 3 while i_fetch_idle=1 -> o_intr_jump at cycle 3 after request, o_intr_addr=0x100C, o_intring=1.
REQ-036 Soft code 2 and hard code 5 same cycle -> hard first (addr base+0x14), after i_intr_finish and EXIT soft serviced (addr base+0x48).
REQ-037 Mask=2'b01 then hard request -> o_pending stays 00, no jump; soft request still serviced.
REQ-038 Second hard request during SERVICE -> o_pending[0]=1, no jump until after EXIT; i_intr_finish in IDLE -> no state change.
REQ-039 Request with i_fetch_idle=0 -> state holds DRAIN until i_inst_complete pulse, ENTER next cycle.
REQ-040 rst asserted during SERVICE -> next cycle o_intring=0, codes 0, pending 00.
